// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with a 2-entry fetch queue toward decode
// Redirects flush the queue and restart fetch at the word-aligned target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [1:0]  fq_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd2;

    logic [31:0] fetch_pc;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic        pop;
    logic        push;

    assign pop  = (count != EMPTY) && id_ready;
    assign push = !redirect_valid && ((count != FULL) || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            count    <= EMPTY;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            // Storage is cleared so the don't-care head outputs stay X-free.
            for (int i = 0; i < 2; i++) begin
                q_pc[i]    <= 32'h0;
                q_instr[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            count    <= EMPTY;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= fetch_pc;
                q_instr[wr_ptr] <= imem_instr;
                wr_ptr          <= ~wr_ptr;
                fetch_pc        <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign imem_pc     = fetch_pc;
    assign id_valid    = (count != EMPTY);
    assign id_pc       = q_pc[rd_ptr];
    assign id_instr    = q_instr[rd_ptr];
    assign id_pc_plus4 = q_pc[rd_ptr] + 32'd4;
    assign fq_count    = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic [31:0] imem_pc_a     [2];
    logic [31:0] imem_instr_a  [2];
    logic        id_valid_a    [2];
    logic [31:0] id_pc_a       [2];
    logic [31:0] id_instr_a    [2];
    logic [31:0] id_pc_plus4_a [2];
    logic [1:0]  fq_count_a    [2];

    ent_t        mq [2][$];
    logic [31:0] mpc [2];
    logic [31:0] rpc [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0006_0613;
        if (a == 32'h4) return 32'h0016_8693;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr_a[0] = mem_word(imem_pc_a[0]);
    assign imem_instr_a[1] = mem_word(imem_pc_a[1]);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_pc(imem_pc_a[0]), .imem_instr(imem_instr_a[0]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid_a[0]),
        .id_pc(id_pc_a[0]), .id_instr(id_instr_a[0]),
        .id_pc_plus4(id_pc_plus4_a[0]), .fq_count(fq_count_a[0])
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_pc(imem_pc_a[1]), .imem_instr(imem_instr_a[1]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid_a[1]),
        .id_pc(id_pc_a[1]), .id_instr(id_instr_a[1]),
        .id_pc_plus4(id_pc_plus4_a[1]), .fq_count(fq_count_a[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Queue-of-entries model: flush on reset/redirect, else retire head then refill.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                mpc[k] = rpc[k];
            end else if (redirect_valid) begin
                mq[k].delete();
                mpc[k] = {redirect_pc[31:2], 2'b00};
            end else begin
                if (mq[k].size() > 0 && id_ready) void'(mq[k].pop_front());
                if (mq[k].size() < 2) begin
                    mq[k].push_back('{pc: mpc[k], instr: mem_word(mpc[k])});
                    mpc[k] = mpc[k] + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            check("fq_count", {30'b0, fq_count_a[k]}, mq[k].size());
            check("id_valid", {31'b0, id_valid_a[k]}, {31'b0, mq[k].size() != 0});
            check("imem_pc", imem_pc_a[k], mpc[k]);
            if (mq[k].size() != 0) begin
                check("id_pc", id_pc_a[k], mq[k][0].pc);
                check("id_instr", id_instr_a[k], mq[k][0].instr);
                check("id_pc_plus4", id_pc_plus4_a[k], mq[k][0].pc + 32'd4);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    initial begin
        rpc[0] = 32'h0000_0000;
        rpc[1] = 32'hFFFF_FFF8;
        mpc[0] = rpc[0];
        mpc[1] = rpc[1];
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        cycle();
        cycle();
        check("rst_fq_count", {30'b0, fq_count_a[0]}, 32'd0);
        check("rst_id_valid", {31'b0, id_valid_a[0]}, 32'd0);
        check("rst_imem_pc_wrap", imem_pc_a[1], 32'hFFFF_FFF8);

        // First fetch after release, and the wrapping instance alongside.
        rst_n = 1'b1;
        cycle();
        check("first_valid", {31'b0, id_valid_a[0]}, 32'd1);
        check("first_pc", id_pc_a[0], 32'h0);
        check("first_instr", id_instr_a[0], 32'h0006_0613);
        check("wrap_pc0", id_pc_a[1], 32'hFFFF_FFF8);
        cycle();
        check("second_pc", id_pc_a[0], 32'h4);
        check("second_instr", id_instr_a[0], 32'h0016_8693);
        check("second_plus4", id_pc_plus4_a[0], 32'h8);
        check("wrap_pc1", id_pc_a[1], 32'hFFFF_FFFC);
        check("wrap_plus4", id_pc_plus4_a[1], 32'h0);
        cycle();
        check("wrap_pc2", id_pc_a[1], 32'h0);

        // Back-pressure from reset.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_fq_count", {30'b0, fq_count_a[0]}, (i == 0) ? 32'd1 : 32'd2);
        end
        check("bp_imem_pc", imem_pc_a[0], 32'h8);
        check("bp_head", id_pc_a[0], 32'h0);
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_order", id_pc_a[0], 32'(i * 4));
            cycle();
            check("full_steady", {30'b0, fq_count_a[0]}, 32'd2);
        end

        // Redirect while FULL.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0016;
        cycle();
        check("redir_fq_count", {30'b0, fq_count_a[0]}, 32'd0);
        check("redir_valid", {31'b0, id_valid_a[0]}, 32'd0);
        check("redir_imem_pc", imem_pc_a[0], 32'h14);
        redirect_valid = 1'b0;
        cycle();
        check("redir_head", id_pc_a[0], 32'h14);

        // Reset pulse beats a redirect while FULL.
        id_ready = 1'b0;
        cycle();
        cycle();
        check("refill_full", {30'b0, fq_count_a[0]}, 32'd2);
        rst_n = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        check("rst_redir_fq", {30'b0, fq_count_a[0]}, 32'd0);
        check("rst_redir_pc", imem_pc_a[0], 32'h0);
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom();
            id_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
